// File: rtl/alu_mdu_if.sv
// alu_mdu_if: operand/control/result bundle between the EX-stage control and the ALU/MDU.
interface alu_mdu_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] i_in1;
    logic [WIDTH-1:0] i_in2;
    logic [4:0]       i_alu_ctrl;
    logic             i_sign;
    logic             i_start;
    logic [WIDTH-1:0] o_out;
    logic             o_zero;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;
    logic             o_div_by_zero;
    modport master(
        output i_in1, i_in2, i_alu_ctrl, i_sign, i_start,
        input  o_out, o_zero, o_busy, o_done, o_hi, o_lo, o_div_by_zero
    );
    modport slave(
        input  i_in1, i_in2, i_alu_ctrl, i_sign, i_start,
        output o_out, o_zero, o_busy, o_done, o_hi, o_lo, o_div_by_zero
    );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: WIDTH-bit EX-stage ALU plus iterative shift-add multiplier / restoring divider
// writing architectural HI/LO registers.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst_n,
    alu_mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t r_state, w_next;
    logic [2*WIDTH-1:0] r_p, w_prod;
    logic [WIDTH-1:0] r_m, r_hi, r_lo, w_a_mag, w_b_mag, w_q, w_r, w_out, w_sra, w_sub;
    logic [WIDTH:0] w_add, w_trial;
    logic [CW-1:0] r_cnt;
    logic r_neg_q, r_neg_r, r_dbz;
    logic w_idle_start, w_go_mul, w_go_div, w_go_mthi, w_go_mtlo, w_last, w_ge, w_lt;

    assign w_idle_start = (r_state == IDLE) && bus.i_start;
    assign w_go_mul = w_idle_start && bus.i_alu_ctrl == 5'd10;
    assign w_go_div = w_idle_start && bus.i_alu_ctrl == 5'd11;
    assign w_go_mthi = w_idle_start && bus.i_alu_ctrl == 5'd14;
    assign w_go_mtlo = w_idle_start && bus.i_alu_ctrl == 5'd15;
    assign w_last = r_cnt == CW'(WIDTH);
    assign w_a_mag = (bus.i_sign && bus.i_in1[WIDTH-1]) ? -bus.i_in1 : bus.i_in1;
    assign w_b_mag = (bus.i_sign && bus.i_in2[WIDTH-1]) ? -bus.i_in2 : bus.i_in2;

    // r_p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign w_add = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
    assign w_trial = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_ge = w_trial >= {1'b0, r_m};
    assign w_sub = w_trial[WIDTH-1:0] - r_m;
    assign w_prod = r_neg_q ? -r_p : r_p;
    assign w_q = r_dbz ? '1 : r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    assign w_r = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = w_go_mul ? MUL : w_go_div ? DIV : IDLE;
        else if (r_state == DONE) w_next = IDLE;
        else if (w_last) w_next = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
            r_m <= '0;
            r_cnt <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz <= 1'b0;
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_go_mul || w_go_div) begin
                r_p <= {{WIDTH{1'b0}}, w_a_mag};
                r_m <= w_b_mag;
                r_cnt <= '0;
                r_neg_q <= bus.i_sign & (bus.i_in1[WIDTH-1] ^ bus.i_in2[WIDTH-1]);
                r_neg_r <= bus.i_sign & bus.i_in1[WIDTH-1];
                r_dbz <= w_go_div && bus.i_in2 == '0;
            end else if (w_go_mthi || w_go_mtlo) begin
                r_dbz <= 1'b0;
            end
            if (w_go_mthi) r_hi <= bus.i_in1;
            if (w_go_mtlo) r_lo <= bus.i_in1;
            if ((r_state == MUL || r_state == DIV) && !w_last) begin
                r_cnt <= r_cnt + 1'b1;
                r_p <= (r_state == MUL) ? {w_add, r_p[WIDTH-1:1]}
                                        : {(w_ge ? w_sub : w_trial[WIDTH-1:0]), r_p[WIDTH-2:0], w_ge};
            end
            if (r_state == MUL && w_last) {r_hi, r_lo} <= w_prod;
            if (r_state == DIV && w_last) begin
                r_hi <= w_r;
                r_lo <= w_q;
            end
        end
    end

    assign w_sra = $signed(bus.i_in2) >>> bus.i_in1[SHW-1:0];
    assign w_lt = bus.i_sign ? ($signed(bus.i_in1) < $signed(bus.i_in2)) : (bus.i_in1 < bus.i_in2);

    always_comb begin
        w_out = '0;
        case (bus.i_alu_ctrl)
            5'd0: w_out = bus.i_in1 & bus.i_in2;
            5'd1: w_out = bus.i_in1 | bus.i_in2;
            5'd2: w_out = bus.i_in1 + bus.i_in2;
            5'd3: w_out = bus.i_in1 - bus.i_in2;
            5'd4: w_out = {{(WIDTH-1){1'b0}}, w_lt};
            5'd5: w_out = ~(bus.i_in1 | bus.i_in2);
            5'd6: w_out = bus.i_in1 ^ bus.i_in2;
            5'd7: w_out = bus.i_in2 << bus.i_in1[SHW-1:0];
            5'd8: w_out = bus.i_sign ? w_sra : bus.i_in2 >> bus.i_in1[SHW-1:0];
            5'd9: w_out = bus.i_in2;
            5'd12: w_out = r_hi;
            5'd13: w_out = r_lo;
            default: w_out = '0;
        endcase
    end

    assign bus.o_out = w_out;
    assign bus.o_zero = w_out == '0;
    assign bus.o_busy = r_state == MUL || r_state == DIV;
    assign bus.o_done = r_state == DONE;
    assign bus.o_hi = r_hi;
    assign bus.o_lo = r_lo;
    assign bus.o_div_by_zero = r_dbz;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized self-checking bench for alu_mdu against a plain-arithmetic reference.
module tb_alu_mdu;
    logic clk, rst_n;
    int n_checks, n_fail;
    logic [31:0] m_hi, m_lo;

    alu_mdu_if #(.WIDTH(32)) b32();
    alu_mdu_if #(.WIDTH(8)) b8();
    alu_mdu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(b32));
    alu_mdu #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    always #5 clk = ~clk;

    function automatic logic [31:0] comb_ref(input logic [4:0] op, input logic sg, input logic [31:0] a, b);
        longint sa, sb, sr;
        int sh;
        logic [31:0] r;
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        sh = int'(a[4:0]);
        sr = sb >> sh;
        case (op)
            5'd0: r = a & b;
            5'd1: r = a | b;
            5'd2: r = a + b;
            5'd3: r = a - b;
            5'd4: r = (sa < sb) ? 32'd1 : 32'd0;
            5'd5: r = ~(a | b);
            5'd6: r = a ^ b;
            5'd7: r = b << sh;
            5'd8: r = sr[31:0];
            5'd9: r = b;
            5'd12: r = m_hi;
            5'd13: r = m_lo;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic void mdu_ref(input logic [4:0] op, input logic sg, input logic [31:0] a, b,
                                    output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        if (op == 5'd10) begin
            p = 64'(sa * sb);
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            h = a;
            l = 32'hFFFFFFFF;
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = r[31:0];
            l = q[31:0];
        end
    endfunction

    task automatic run_mdu(input logic [4:0] op, input logic sg, input logic [31:0] a, b, input bit spam);
        logic [31:0] eh, el;
        logic edbz;
        int busy_cyc, done_k;
        mdu_ref(op, sg, a, b, eh, el);
        edbz = (op == 5'd11) && (b == 32'd0);
        b32.i_alu_ctrl = op;
        b32.i_sign = sg;
        b32.i_in1 = a;
        b32.i_in2 = b;
        b32.i_start = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (b32.o_busy !== 1'b1 || b32.o_div_by_zero !== edbz) begin
            n_fail++;
            $display("FAIL start op%0d: busy=%b dbz=%b, expected busy=1 dbz=%b", op, b32.o_busy, b32.o_div_by_zero, edbz);
        end
        busy_cyc = 0;
        done_k = -1;
        for (int k = 0; k < 100; k++) begin
            if (b32.o_done === 1'b1) begin
                done_k = k;
                break;
            end
            if (b32.o_busy === 1'b1) busy_cyc++;
            b32.i_in1 = $urandom;
            b32.i_in2 = $urandom;
            if (!spam) begin
                b32.i_start = 1'b0;
                b32.i_alu_ctrl = 5'd13;
                #1;
                n_checks++;
                if (b32.o_out !== m_lo) begin
                    n_fail++;
                    $display("FAIL mflo_busy: out=%h, expected old lo %h", b32.o_out, m_lo);
                end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (done_k != 33 || busy_cyc != 33 || b32.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL latency op%0d: done after edge %0d busy_cycles=%0d, expected 33 and 33", op, done_k, busy_cyc);
        end
        n_checks++;
        if (b32.o_hi !== eh || b32.o_lo !== el) begin
            n_fail++;
            $display("FAIL result op%0d sg%0d %h,%h: hi=%h lo=%h, expected hi=%h lo=%h", op, sg, a, b, b32.o_hi, b32.o_lo, eh, el);
        end
        n_checks++;
        if (b32.o_div_by_zero !== edbz) begin
            n_fail++;
            $display("FAIL dbz_flag op%0d: dbz=%b, expected %b", op, b32.o_div_by_zero, edbz);
        end
        @(posedge clk);
        #1;
        b32.i_start = 1'b0;
        n_checks++;
        if (b32.o_done !== 1'b0 || b32.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b busy=%b one cycle later, expected 0 0", b32.o_done, b32.o_busy);
        end
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic run8(input logic [4:0] op, input logic sg, input logic [7:0] a, b);
        int sa, sb, done_k;
        logic [15:0] p;
        logic [7:0] eh, el;
        sa = sg ? int'($signed(a)) : int'(a);
        sb = sg ? int'($signed(b)) : int'(b);
        if (op == 5'd10) begin
            p = 16'(sa * sb);
            eh = p[15:8];
            el = p[7:0];
        end else begin
            el = 8'(sa / sb);
            eh = 8'(sa % sb);
        end
        b8.i_alu_ctrl = op;
        b8.i_sign = sg;
        b8.i_in1 = a;
        b8.i_in2 = b;
        b8.i_start = 1'b1;
        @(posedge clk);
        #1;
        b8.i_start = 1'b0;
        done_k = -1;
        for (int k = 1; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (b8.o_done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        n_checks++;
        if (done_k != 9 || b8.o_hi !== eh || b8.o_lo !== el) begin
            n_fail++;
            $display("FAIL w8 op%0d sg%0d %h,%h: done edge %0d hi=%h lo=%h, expected 9 hi=%h lo=%h",
                     op, sg, a, b, done_k, b8.o_hi, b8.o_lo, eh, el);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        n_checks++;
        if (b32.o_hi !== 32'd0 || b32.o_lo !== 32'd0 || b32.o_busy !== 1'b0 || b32.o_done !== 1'b0 || b32.o_div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dbz=%b, expected all 0",
                     b32.o_hi, b32.o_lo, b32.o_busy, b32.o_done, b32.o_div_by_zero);
        end
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_comb;
        logic [4:0] d_op [10] = '{5'd2, 5'd3, 5'd4, 5'd4, 5'd8, 5'd8, 5'd7, 5'd4, 5'd16, 5'd5};
        logic d_sg [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] d_a [10] = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'h80000000, 32'd4, 32'd4, 32'd31, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] d_b [10] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'hF0000000, 32'hF0000000, 32'd1, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        logic [31:0] d_e [10] = '{32'h80000000, 32'd0, 32'd1, 32'd0, 32'hFF000000, 32'h0F000000, 32'h80000000, 32'd0, 32'd0, 32'hFFFFFFFF};
        logic [31:0] e;
        b32.i_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            b32.i_alu_ctrl = d_op[i];
            b32.i_sign = d_sg[i];
            b32.i_in1 = d_a[i];
            b32.i_in2 = d_b[i];
            #2;
            n_checks++;
            if (b32.o_out !== d_e[i] || b32.o_zero !== (d_e[i] == 32'd0)) begin
                n_fail++;
                $display("FAIL comb_dir%0d op%0d: out=%h zero=%b, expected %h", i, d_op[i], b32.o_out, b32.o_zero, d_e[i]);
            end
        end
        for (int i = 0; i < 80; i++) begin
            b32.i_alu_ctrl = 5'($urandom_range(0, 31));
            b32.i_sign = 1'($urandom_range(0, 1));
            b32.i_in1 = $urandom;
            b32.i_in2 = (i % 5 == 0) ? b32.i_in1 : $urandom;
            #2;
            e = comb_ref(b32.i_alu_ctrl, b32.i_sign, b32.i_in1, b32.i_in2);
            n_checks++;
            if (b32.o_out !== e || b32.o_zero !== (e == 32'd0)) begin
                n_fail++;
                $display("FAIL comb_rnd op%0d sg%0d %h,%h: out=%h zero=%b, expected %h",
                         b32.i_alu_ctrl, b32.i_sign, b32.i_in1, b32.i_in2, b32.o_out, b32.o_zero, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult;
        run_mdu(5'd10, 1'b1, -32'sd3, 32'd7, 1'b0);
        run_mdu(5'd10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        for (int i = 0; i < 5; i++) run_mdu(5'd10, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
    endtask

    task automatic test_div;
        run_mdu(5'd11, 1'b1, -32'sd7, 32'd2, 1'b0);
        run_mdu(5'd11, 1'b0, 32'd100, 32'd7, 1'b0);
        run_mdu(5'd11, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        for (int i = 0; i < 6; i++)
            run_mdu(5'd11, 1'($urandom_range(0, 1)), $urandom, $urandom >> $urandom_range(0, 30), 1'b0);
    endtask

    task automatic test_div_by_zero;
        run_mdu(5'd11, 1'b0, 32'd9, 32'd0, 1'b0);
        run_mdu(5'd10, 1'b1, $urandom, $urandom, 1'b0);
        run_mdu(5'd11, 1'b1, -32'sd20, 32'd0, 1'b0);
    endtask

    task automatic test_start_ignore;
        run_mdu(5'd10, 1'b1, $urandom, $urandom, 1'b1);
        run_mdu(5'd11, 1'b1, $urandom, $urandom >> 8, 1'b1);
    endtask

    task automatic test_mthi_mtlo;
        logic [31:0] v;
        v = $urandom;
        b32.i_alu_ctrl = 5'd14;
        b32.i_in1 = 32'h1234;
        b32.i_start = 1'b1;
        @(posedge clk);
        #1;
        b32.i_start = 1'b0;
        b32.i_alu_ctrl = 5'd12;
        #1;
        n_checks++;
        if (b32.o_hi !== 32'h1234 || b32.o_out !== 32'h1234 || b32.o_done !== 1'b0 || b32.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi: hi=%h out=%h done=%b busy=%b, expected 1234 1234 0 0", b32.o_hi, b32.o_out, b32.o_done, b32.o_busy);
        end
        m_hi = 32'h1234;
        b32.i_alu_ctrl = 5'd15;
        b32.i_in1 = v;
        b32.i_start = 1'b1;
        @(posedge clk);
        #1;
        b32.i_start = 1'b0;
        b32.i_alu_ctrl = 5'd13;
        #1;
        n_checks++;
        if (b32.o_lo !== v || b32.o_out !== v || b32.o_hi !== m_hi || b32.o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo: lo=%h out=%h hi=%h done=%b, expected %h %h %h 0", b32.o_lo, b32.o_out, b32.o_hi, b32.o_done, v, v, m_hi);
        end
        m_lo = v;
        b32.i_alu_ctrl = 5'd3;
        b32.i_in1 = $urandom;
        b32.i_start = 1'b1;
        @(posedge clk);
        #1;
        b32.i_start = 1'b0;
        n_checks++;
        if (b32.o_busy !== 1'b0 || b32.o_hi !== m_hi || b32.o_lo !== m_lo) begin
            n_fail++;
            $display("FAIL start_other_op: busy=%b hi=%h lo=%h, expected 0 %h %h", b32.o_busy, b32.o_hi, b32.o_lo, m_hi, m_lo);
        end
    endtask

    task automatic test_back_to_back;
        run_mdu(5'd11, 1'b1, $urandom, $urandom >> 4, 1'b0);
        run_mdu(5'd10, 1'b0, $urandom, $urandom, 1'b0);
        run_mdu(5'd11, 1'b0, $urandom, $urandom >> 20, 1'b0);
    endtask

    task automatic test_reset_abort;
        b32.i_alu_ctrl = 5'd11;
        b32.i_sign = 1'b1;
        b32.i_in1 = $urandom;
        b32.i_in2 = 32'd0;
        b32.i_start = 1'b1;
        @(posedge clk);
        #1;
        b32.i_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (b32.o_busy !== 1'b0 || b32.o_done !== 1'b0 || b32.o_hi !== 32'd0 || b32.o_lo !== 32'd0 || b32.o_div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h dbz=%b, expected all 0",
                     b32.o_busy, b32.o_done, b32.o_hi, b32.o_lo, b32.o_div_by_zero);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        #2 rst_n = 1'b1;
        run_mdu(5'd10, 1'b1, $urandom, $urandom, 1'b0);
    endtask

    task automatic test_width8;
        run8(5'd10, 1'b0, 8'd5, 8'd6);
        run8(5'd11, 1'b1, 8'h80, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            run8(5'd10, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            run8(5'd11, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(1, 255)));
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        n_checks = 0;
        n_fail = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        b32.i_in1 = '0;
        b32.i_in2 = '0;
        b32.i_alu_ctrl = '0;
        b32.i_sign = 1'b0;
        b32.i_start = 1'b0;
        b8.i_in1 = '0;
        b8.i_in2 = '0;
        b8.i_alu_ctrl = '0;
        b8.i_sign = 1'b0;
        b8.i_start = 1'b0;
        test_reset;
        test_comb;
        test_mult;
        test_div;
        test_div_by_zero;
        test_start_ignore;
        test_mthi_mtlo;
        test_back_to_back;
        test_reset_abort;
        test_width8;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
